// File: rtl/memory_byte_sequencer_pkg.sv
// Shared definitions for the memory byte sequencer.
//   state_e        : FSM state encoding
//   SZ_*           : access size codes carried on the size port
//   INVALID_ADDR   : empty-stack sentinel emitted by the address handler
//   lane_count()   : number of byte lanes touched by a given size code
package memory_byte_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FINISH,
        ST_ERR
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [31:0] INVALID_ADDR = 32'hFFFF_FFFF;

    // Reserved size maps to zero lanes; it never reaches RUN.
    function automatic logic [2:0] lane_count(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: lane_count = 3'd1;
            SZ_HALF: lane_count = 3'd2;
            SZ_WORD: lane_count = 3'd4;
            default: lane_count = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/memory_byte_sequencer_byte_lane_assembler.sv
// Byte lane steering for the memory byte sequencer.
//   addrs_in / wdata_in / sel : lane-select mux producing the RAM address and write byte
//   lane_addr / lane_wdata    : selected lane (combinational)
//   rd_clr / rd_we / rd_lane / rd_byte : read-word lane register control
//   rdata                     : assembled read word (registered, cleared on async reset)
module byte_lane_assembler #(
    parameter int unsigned MEM_AW = 13
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*MEM_AW-1:0]   addrs_in,
    input  logic [31:0]           wdata_in,
    input  logic [1:0]            sel,
    output logic [MEM_AW-1:0]     lane_addr,
    output logic [7:0]            lane_wdata,
    input  logic                  rd_clr,
    input  logic                  rd_we,
    input  logic [1:0]            rd_lane,
    input  logic [7:0]            rd_byte,
    output logic [31:0]           rdata
);

    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    always_comb begin
        lane_addr  = addrs_in[sel*MEM_AW +: MEM_AW];
        lane_wdata = wdata_in[{sel, 3'b000} +: 8];
    end

    // Clear wins over a capture so a newly accepted start always begins from zero.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_clr) begin
            rdata_d = '0;
        end else if (rd_we) begin
            rdata_d[{rd_lane, 3'b000} +: 8] = rd_byte;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/memory_byte_sequencer.sv
// Memory byte sequencer: performs a 1/2/4-byte access on a byte-wide RAM, one
// lane per cycle, using the four per-byte addresses from the address handler.
//   clock, reset (async active-low)
//   start, write_en, size, byte0..byte3, wdata : request (sampled in IDLE)
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata : RAM interface (registered outputs)
//   rdata, busy, done, error : result and status
module memory_byte_sequencer #(
    parameter int unsigned MEM_AW       = 13,
    parameter logic [31:0] INVALID_ADDR = memory_byte_sequencer_pkg::INVALID_ADDR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              write_en,
    input  logic [1:0]        size,
    input  logic [31:0]       byte0,
    input  logic [31:0]       byte1,
    input  logic [31:0]       byte2,
    input  logic [31:0]       byte3,
    input  logic [31:0]       wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    import memory_byte_sequencer_pkg::*;

    state_e                   state_d, state_q;
    logic [1:0]               idx_d, idx_q;
    logic                     we_d, we_q;
    logic [1:0]               size_d, size_q;
    logic [3:0][MEM_AW-1:0]   addrs_d, addrs_q;
    logic [31:0]              wdata_d, wdata_q;
    logic                     mem_en_d, mem_en_q;
    logic                     mem_we_d, mem_we_q;
    logic [MEM_AW-1:0]        mem_addr_d, mem_addr_q;
    logic [7:0]               mem_wdata_d, mem_wdata_q;
    logic                     busy_d, busy_q;
    logic                     done_d, done_q;
    logic                     error_d, error_q;

    logic [3:0][31:0]         byte_in;
    logic                     req_bad;
    logic [1:0]               last_idx;
    logic                     rd_clr, rd_we;
    logic [1:0]               rd_lane;
    logic [MEM_AW-1:0]        lane_addr;
    logic [7:0]               lane_wdata;

    assign byte_in = {byte3, byte2, byte1, byte0};

    // Only the lanes the requested size will touch are range-checked.
    always_comb begin
        req_bad = (size == SZ_RSVD);
        for (int i = 0; i < 4; i++) begin
            if (i < int'(lane_count(size))) begin
                if (byte_in[i] == INVALID_ADDR || (byte_in[i] >> MEM_AW) != 32'd0) begin
                    req_bad = 1'b1;
                end
            end
        end
    end

    assign last_idx = 2'(lane_count(size_q) - 3'd1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        size_d  = size_q;
        addrs_d = addrs_q;
        wdata_d = wdata_q;
        rd_clr  = 1'b0;
        rd_we   = 1'b0;
        rd_lane = idx_q - 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    we_d    = write_en;
                    size_d  = size;
                    for (int i = 0; i < 4; i++) begin
                        addrs_d[i] = byte_in[i][MEM_AW-1:0];
                    end
                    wdata_d = wdata;
                    idx_d   = 2'd0;
                    rd_clr  = 1'b1;
                    state_d = req_bad ? ST_ERR : ST_RUN;
                end
            end
            ST_RUN: begin
                // Read data lags the issue by one cycle, so lane idx-1 lands now.
                if (!we_q && idx_q != 2'd0) begin
                    rd_we = 1'b1;
                end
                if (idx_q == last_idx) begin
                    state_d = we_q ? ST_FINISH : ST_DRAIN;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_DRAIN: begin
                rd_we   = 1'b1;
                rd_lane = last_idx;
                state_d = ST_FINISH;
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so RAM signals line up with RUN cycles.
        mem_en_d    = (state_d == ST_RUN);
        mem_we_d    = mem_en_d && we_d;
        mem_addr_d  = mem_en_d ? lane_addr  : '0;
        mem_wdata_d = mem_en_d ? lane_wdata : '0;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FINISH) || (state_d == ST_ERR);
        error_d     = (state_d == ST_ERR);
    end

    byte_lane_assembler #(
        .MEM_AW(MEM_AW)
    ) u_lanes (
        .clock     (clock),
        .reset     (reset),
        .addrs_in  (addrs_d),
        .wdata_in  (wdata_d),
        .sel       (idx_d),
        .lane_addr (lane_addr),
        .lane_wdata(lane_wdata),
        .rd_clr    (rd_clr),
        .rd_we     (rd_we),
        .rd_lane   (rd_lane),
        .rd_byte   (mem_rdata),
        .rdata     (rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            addrs_q     <= '0;
            wdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addrs_q     <= addrs_d;
            wdata_q     <= wdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
